// File: rtl/vga_pattern_regfile.sv
// vga_pattern_regfile
//   Parses framed UART command packets (SYNC, ADDR, DATA, CHK) into a shadow
//   register file and commits shadow -> active only on a frame-start pulse.
//   Each packet produces an ACK/NAK byte on a ready/valid TX interface.
//
// Optional build macro: VGA_PATTERN_REGFILE_READBACK_EN
//   When defined, ADDR[7]=1 requests a readback of active register ADDR[6:0];
//   the response byte carries the register value instead of ACK_BYTE.
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_rx_byte/valid     received byte and its one-cycle strobe
//   i_frame_start       one-cycle pulse at start of vertical blank
//   o_tx_byte/valid     pending response byte, held until i_tx_ready
//   i_tx_ready          consumer accepts response
//   o_regs              active registers, reg k at [8k+7:8k]
//   o_commit            pulse the cycle after a shadow->active commit
//   o_err_timeout       pulse when a partial packet times out
//   o_resp_drop         pulse when a response is lost to a pending one
module vga_pattern_regfile #(
  parameter int         NUM_REGS       = 8,
  parameter int         TIMEOUT_CYCLES = 2170,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter logic [7:0] ACK_BYTE       = 8'h06,
  parameter logic [7:0] NAK_BYTE       = 8'h15
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [7:0]            i_rx_byte,
  input  logic                  i_rx_valid,
  input  logic                  i_frame_start,
  output logic [7:0]            o_tx_byte,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic [8*NUM_REGS-1:0] o_regs,
  output logic                  o_commit,
  output logic                  o_err_timeout,
  output logic                  o_resp_drop
);

  localparam int             AW         = $clog2(NUM_REGS);
  localparam int             CW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  TO_LAST    = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]     NUM_REGS_W = 9'(NUM_REGS);

  typedef enum logic [1:0] {S_IDLE, S_GET_ADDR, S_GET_DATA, S_GET_CHK} state_t;

  state_t         state_q, state_d;
  logic [7:0]     addr_q, addr_d;
  logic [7:0]     data_q, data_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           dirty_q, dirty_d;
  logic [7:0]     shadow_q [NUM_REGS];
  logic [7:0]     shadow_d [NUM_REGS];
  logic [7:0]     active_q [NUM_REGS];
  logic [7:0]     active_d [NUM_REGS];
  logic [7:0]     tx_byte_q, tx_byte_d;
  logic           tx_valid_q, tx_valid_d;
  logic           commit_q, commit_d;
  logic           err_timeout_q, err_timeout_d;
  logic           resp_drop_q, resp_drop_d;

  logic           gen;
  logic           wr_en;
  logic           chk_ok;
  logic           accept;
  logic [7:0]     resp;
  logic [AW-1:0]  idx;

  assign idx = addr_q[AW-1:0];

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    data_d        = data_q;
    cnt_d         = cnt_q;
    dirty_d       = dirty_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    tx_byte_d     = tx_byte_q;
    tx_valid_d    = tx_valid_q;
    commit_d      = 1'b0;
    err_timeout_d = 1'b0;
    resp_drop_d   = 1'b0;
    gen           = 1'b0;
    wr_en         = 1'b0;
    resp          = NAK_BYTE;
    chk_ok        = 1'b0;
    accept        = tx_valid_q && i_tx_ready;

    if (i_rx_valid || state_q == S_IDLE) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (i_rx_valid) begin
      case (state_q)
        S_IDLE: begin
          if (i_rx_byte == SYNC_BYTE) state_d = S_GET_ADDR;
        end
        S_GET_ADDR: begin
          addr_d  = i_rx_byte;
          state_d = S_GET_DATA;
        end
        S_GET_DATA: begin
          data_d  = i_rx_byte;
          state_d = S_GET_CHK;
        end
        default: begin
          state_d = S_IDLE;
          gen     = 1'b1;
          chk_ok  = (i_rx_byte == (addr_q ^ data_q));
`ifdef VGA_PATTERN_REGFILE_READBACK_EN
          if (addr_q[7]) begin
            if (chk_ok && ({2'b00, addr_q[6:0]} < NUM_REGS_W)) resp = active_q[idx];
          end else if (chk_ok && ({1'b0, addr_q} < NUM_REGS_W)) begin
            wr_en = 1'b1;
            resp  = ACK_BYTE;
          end
`else
          if (chk_ok && ({1'b0, addr_q} < NUM_REGS_W)) begin
            wr_en = 1'b1;
            resp  = ACK_BYTE;
          end
`endif
        end
      endcase
    end else if (state_q != S_IDLE && cnt_q >= TO_LAST) begin
      state_d       = S_IDLE;
      err_timeout_d = 1'b1;
    end

    // A response accepted this cycle frees the slot for a new one.
    if (gen) begin
      if (!tx_valid_q || accept) begin
        tx_valid_d = 1'b1;
        tx_byte_d  = resp;
      end else begin
        resp_drop_d = 1'b1;
      end
    end else if (accept) begin
      tx_valid_d = 1'b0;
    end

    // Commit uses the pre-write shadow; a same-cycle write re-marks dirty.
    if (i_frame_start && dirty_q) begin
      active_d = shadow_q;
      dirty_d  = 1'b0;
      commit_d = 1'b1;
    end
    if (wr_en) begin
      shadow_d[idx] = data_q;
      dirty_d       = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      data_q        <= '0;
      cnt_q         <= '0;
      dirty_q       <= 1'b0;
      shadow_q      <= '{default: '0};
      active_q      <= '{default: '0};
      tx_byte_q     <= '0;
      tx_valid_q    <= 1'b0;
      commit_q      <= 1'b0;
      err_timeout_q <= 1'b0;
      resp_drop_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      cnt_q         <= cnt_d;
      dirty_q       <= dirty_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      tx_byte_q     <= tx_byte_d;
      tx_valid_q    <= tx_valid_d;
      commit_q      <= commit_d;
      err_timeout_q <= err_timeout_d;
      resp_drop_q   <= resp_drop_d;
    end
  end

  always_comb begin
    o_regs = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      o_regs[8*k +: 8] = active_q[k];
    end
  end

  assign o_tx_byte     = tx_byte_q;
  assign o_tx_valid    = tx_valid_q;
  assign o_commit      = commit_q;
  assign o_err_timeout = err_timeout_q;
  assign o_resp_drop   = resp_drop_q;

endmodule

// File: tb/tb_vga_pattern_regfile.sv
// Directed testbench for vga_pattern_regfile (NUM_REGS=8, short timeout).
module tb_vga_pattern_regfile;

  localparam int NR = 8;
  localparam int TO = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_byte;
  logic          rx_valid;
  logic          frame_start;
  logic [7:0]    tx_byte;
  logic          tx_valid;
  logic          tx_ready;
  logic [8*NR-1:0] regs;
  logic          commit;
  logic          err_timeout;
  logic          resp_drop;

  int total = 0;
  int bad   = 0;

  vga_pattern_regfile #(
    .NUM_REGS       (NR),
    .TIMEOUT_CYCLES (TO),
    .SYNC_BYTE      (8'hA5),
    .ACK_BYTE       (8'h06),
    .NAK_BYTE       (8'h15)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_rx_byte     (rx_byte),
    .i_rx_valid    (rx_valid),
    .i_frame_start (frame_start),
    .o_tx_byte     (tx_byte),
    .o_tx_valid    (tx_valid),
    .i_tx_ready    (tx_ready),
    .o_regs        (regs),
    .o_commit      (commit),
    .o_err_timeout (err_timeout),
    .o_resp_drop   (resp_drop)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fs);
    rx_byte     = b;
    rx_valid    = 1'b1;
    frame_start = fs;
    tick(1);
    rx_valid    = 1'b0;
    frame_start = 1'b0;
  endtask

  // Sends a full packet; fs applies a frame-start pulse with the CHK byte.
  task automatic send_pkt(input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] c, input logic fs);
    send_byte(8'hA5, 1'b0);
    send_byte(a, 1'b0);
    send_byte(d, 1'b0);
    send_byte(c, fs);
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    total++; if (regs !== '0) begin bad++; $display("FAIL reset_regs got=%h exp=0", regs); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    total++; if (tx_byte !== 8'h00) begin bad++; $display("FAIL reset_tx_byte got=%h exp=00", tx_byte); end
    total++; if ({commit, err_timeout, resp_drop} !== 3'b000) begin bad++; $display("FAIL reset_pulses got=%b exp=000", {commit, err_timeout, resp_drop}); end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_write_commit();
    send_pkt(8'h02, 8'h3C, 8'h3E, 1'b0);
    total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL wc_tx_valid got=%b exp=1", tx_valid); end
    total++; if (tx_byte !== 8'h06) begin bad++; $display("FAIL wc_ack got=%h exp=06", tx_byte); end
    total++; if (regs !== '0) begin bad++; $display("FAIL wc_no_early got=%h exp=0", regs); end
    tick(1);
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL wc_tx_clear got=%b exp=0", tx_valid); end
    frame_pulse();
    total++; if (commit !== 1'b1) begin bad++; $display("FAIL wc_commit got=%b exp=1", commit); end
    total++; if (regs !== 64'h0000_0000_003C_0000) begin bad++; $display("FAIL wc_regs got=%h exp=00000000003c0000", regs); end
    tick(1);
    total++; if (commit !== 1'b0) begin bad++; $display("FAIL wc_commit_once got=%b exp=0", commit); end
    frame_pulse();
    total++; if (commit !== 1'b0) begin bad++; $display("FAIL wc_clean_frame got=%b exp=0", commit); end
  endtask

  task automatic test_bad_packets();
    send_pkt(8'h01, 8'h10, 8'h00, 1'b0);
    total++; if (tx_byte !== 8'h15 || tx_valid !== 1'b1) begin bad++; $display("FAIL bad_chk got=%h/%b exp=15/1", tx_byte, tx_valid); end
    tick(1);
    send_pkt(8'h09, 8'h01, 8'h08, 1'b0);
    total++; if (tx_byte !== 8'h15 || tx_valid !== 1'b1) begin bad++; $display("FAIL bad_range got=%h/%b exp=15/1", tx_byte, tx_valid); end
    tick(1);
    frame_pulse();
    total++; if (commit !== 1'b0) begin bad++; $display("FAIL bad_no_commit got=%b exp=0", commit); end
    total++; if (regs !== 64'h0000_0000_003C_0000) begin bad++; $display("FAIL bad_regs got=%h exp=00000000003c0000", regs); end
  endtask

  task automatic test_timeout();
    int pulses = 0;
    int first  = -1;
    int txs    = 0;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h03, 1'b0);
    for (int i = 1; i <= TO + 5; i++) begin
      tick(1);
      if (err_timeout === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
      if (tx_valid === 1'b1) txs++;
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL to_pulses got=%0d exp=1", pulses); end
    total++; if (first !== TO) begin bad++; $display("FAIL to_cycle got=%0d exp=%0d", first, TO); end
    total++; if (txs !== 0) begin bad++; $display("FAIL to_no_resp got=%0d exp=0", txs); end
    send_pkt(8'h03, 8'h07, 8'h04, 1'b0);
    total++; if (tx_byte !== 8'h06 || tx_valid !== 1'b1) begin bad++; $display("FAIL to_recover got=%h/%b exp=06/1", tx_byte, tx_valid); end
    tick(1);
    frame_pulse();
    total++; if (regs !== 64'h0000_0000_073C_0000) begin bad++; $display("FAIL to_regs got=%h exp=00000000073c0000", regs); end
  endtask

  task automatic test_commit_collision();
    send_pkt(8'h00, 8'h05, 8'h05, 1'b0);
    frame_pulse();
    total++; if (commit !== 1'b1) begin bad++; $display("FAIL col_adj_commit got=%b exp=1", commit); end
    total++; if (regs !== 64'h0000_0000_073C_0005) begin bad++; $display("FAIL col_adj_regs got=%h exp=00000000073c0005", regs); end
    send_pkt(8'h05, 8'h11, 8'h14, 1'b0);
    send_pkt(8'h01, 8'h22, 8'h23, 1'b1);
    total++; if (commit !== 1'b1) begin bad++; $display("FAIL col_commit got=%b exp=1", commit); end
    total++; if (regs !== 64'h0000_1100_073C_0005) begin bad++; $display("FAIL col_regs got=%h exp=00001100073c0005", regs); end
    tick(2);
    frame_pulse();
    total++; if (commit !== 1'b1) begin bad++; $display("FAIL col_next_commit got=%b exp=1", commit); end
    total++; if (regs !== 64'h0000_1100_073C_2205) begin bad++; $display("FAIL col_next_regs got=%h exp=00001100073c2205", regs); end
  endtask

  task automatic test_back_to_back();
    int xfers = 0;
    tx_ready = 1'b0;
    send_pkt(8'h06, 8'h5A, 8'h5C, 1'b0);
    total++; if (tx_byte !== 8'h06 || tx_valid !== 1'b1) begin bad++; $display("FAIL bp_first got=%h/%b exp=06/1", tx_byte, tx_valid); end
    total++; if (resp_drop !== 1'b0) begin bad++; $display("FAIL bp_no_drop got=%b exp=0", resp_drop); end
    send_pkt(8'h07, 8'h81, 8'h86, 1'b0);
    total++; if (resp_drop !== 1'b1) begin bad++; $display("FAIL bp_drop got=%b exp=1", resp_drop); end
    total++; if (tx_byte !== 8'h06 || tx_valid !== 1'b1) begin bad++; $display("FAIL bp_held got=%h/%b exp=06/1", tx_byte, tx_valid); end
    tick(1);
    total++; if (resp_drop !== 1'b0) begin bad++; $display("FAIL bp_drop_once got=%b exp=0", resp_drop); end
    tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (tx_valid === 1'b1) xfers++;
      tick(1);
    end
    total++; if (xfers !== 1) begin bad++; $display("FAIL bp_xfers got=%0d exp=1", xfers); end
    frame_pulse();
    total++; if (regs !== 64'h815A_1100_073C_2205) begin bad++; $display("FAIL bp_regs got=%h exp=815a1100073c2205", regs); end
  endtask

  task automatic test_readback();
    logic [7:0] exp_rb;
`ifdef VGA_PATTERN_REGFILE_READBACK_EN
    exp_rb = 8'h77;
`else
    exp_rb = 8'h15;
`endif
    send_pkt(8'h04, 8'h77, 8'h73, 1'b0);
    tick(1);
    frame_pulse();
    total++; if (regs[39:32] !== 8'h77) begin bad++; $display("FAIL rb_setup got=%h exp=77", regs[39:32]); end
    send_pkt(8'h84, 8'h00, 8'h84, 1'b0);
    total++; if (tx_byte !== exp_rb || tx_valid !== 1'b1) begin bad++; $display("FAIL rb_resp got=%h/%b exp=%h/1", tx_byte, tx_valid, exp_rb); end
    tick(1);
    frame_pulse();
    total++; if (regs !== 64'h815A_1177_073C_2205) begin bad++; $display("FAIL rb_no_write got=%h exp=815a1177073c2205", regs); end
  endtask

  task automatic test_reset_mid_packet();
    tx_ready = 1'b0;
    send_pkt(8'h02, 8'h44, 8'h46, 1'b0);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tx_ready = 1'b1;
    total++; if (regs !== '0 || tx_valid !== 1'b0) begin bad++; $display("FAIL rst_mid got=%h/%b exp=0/0", regs, tx_valid); end
    send_byte(8'h33, 1'b0);
    send_byte(8'h32, 1'b0);
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_discard got=%b exp=0", tx_valid); end
    frame_pulse();
    total++; if (commit !== 1'b0) begin bad++; $display("FAIL rst_mid_clean got=%b exp=0", commit); end
  endtask

  initial begin
    rst         = 1'b1;
    rx_byte     = '0;
    rx_valid    = 1'b0;
    frame_start = 1'b0;
    tx_ready    = 1'b1;
    #1;
    test_reset();
    test_write_commit();
    test_bad_packets();
    test_timeout();
    test_commit_collision();
    test_back_to_back();
    test_readback();
    test_reset_mid_packet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
